// File: rtl/jerky_checker_pkg.sv
// Shared types and pattern helpers for the jerky counter checker.
// Values are handled at JERKY_MAX_W bits so that one package serves any WIDTH up to 32.
package jerky_pkg;

  localparam int JERKY_WIDTH   = 8;
  localparam int JERKY_MAX_W   = 32;
  localparam int JERKY_MSB_BIT = JERKY_WIDTH - 1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  typedef logic [JERKY_MAX_W-1:0] jword_t;

  // Next expected value after a matched sample; top_pow is 2^(WIDTH-1).
  function automatic jword_t jerky_next(input jword_t last_pow, input jword_t sample,
                                        input jword_t top_pow);
    if (sample == jword_t'(1)) begin
      return (last_pow == top_pow) ? jword_t'(2) : (last_pow << 1);
    end
    return jword_t'(1);
  endfunction

  function automatic logic is_onehot(input jword_t v);
    return (v != '0) && ((v & (v - jword_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/jerky_checker_if.sv
// Stream-in / status-out bundle of the jerky checker.
// Handshake: count_in is consumed on a rising clock edge only while count_valid is high; there is no backpressure.
interface jerky_checker_if
  import jerky_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) ();
  logic [WIDTH-1:0] count_in;
  logic             count_valid;
  logic             locked;
  logic [WIDTH-1:0] expected;
  logic             mismatch;
  logic             wrap;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] wrap_count;
  chk_state_t       dbg_state;
`ifdef JERKY_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] first_err;
  logic             first_err_vld;
`endif

  modport master (
    output count_in, count_valid,
    input  locked, expected, mismatch, wrap, err_count, wrap_count, dbg_state
`ifdef JERKY_CHECKER_CAPTURE_EN
    , input first_err, first_err_vld
`endif
  );

  modport slave (
    input  count_in, count_valid,
    output locked, expected, mismatch, wrap, err_count, wrap_count, dbg_state
`ifdef JERKY_CHECKER_CAPTURE_EN
    , output first_err, first_err_vld
`endif
  );
endinterface

// File: rtl/jerky_expect_gen.sv
// Tracks the last power of two seen and the value the checker expects next.
// clear has priority over load, and load has priority over advance.
module jerky_expect_gen
  import jerky_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             advance_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic [WIDTH-1:0] expected_o
);
  localparam jword_t TOP_POW = jword_t'(1) << (WIDTH - 1);

  logic [WIDTH-1:0] last_pow_q, last_pow_d;
  logic [WIDTH-1:0] expected_q, expected_d;

  always_comb begin
    last_pow_d = last_pow_q;
    expected_d = expected_q;
    if (clear_i) begin
      expected_d = '0;
    end else if (load_i) begin
      last_pow_d = sample_i;
      expected_d = WIDTH'(1);
    end else if (advance_i) begin
      expected_d = WIDTH'(jerky_next(jword_t'(last_pow_q), jword_t'(sample_i), TOP_POW));
      if (sample_i != WIDTH'(1)) last_pow_d = sample_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_pow_q <= '0;
      expected_q <= '0;
    end else begin
      last_pow_q <= last_pow_d;
      expected_q <= expected_d;
    end
  end

  assign expected_o = expected_q;
endmodule

// File: rtl/jerky_checker.sv
// Lock-and-verify checker for the 1,2,1,4,...,1,2^(WIDTH-1) jerky counter stream.
// Define JERKY_CHECKER_CAPTURE_EN to add the sticky first-error capture (first_err, first_err_vld).
module jerky_checker
  import jerky_pkg::*;
#(
  parameter int WIDTH       = JERKY_WIDTH,
  parameter int LOCK_THRESH = 4,
  parameter int CNT_W       = 8
) (
  input  logic      clock,
  input  logic      reset,
  jerky_checker_if.slave bus
);
  localparam jword_t TOP_POW = jword_t'(1) << (WIDTH - 1);

  chk_state_t       state_q, state_d;
  logic [7:0]       run_q, run_d;
  logic             mismatch_q, mismatch_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] wrapc_q, wrapc_d;
  logic             load, advance, clear;
  logic [WIDTH-1:0] expected;

  jword_t sample;
  logic   valid, hit, seed_ok;
  assign sample  = jword_t'(bus.count_in);
  assign valid   = bus.count_valid;
  assign hit     = (bus.count_in == expected);
  // A seed must be a power of two other than 1, so its position in the period is unambiguous.
  assign seed_ok = is_onehot(sample) && (sample != jword_t'(1)) && (sample <= TOP_POW);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= HUNT;
      run_q      <= '0;
      mismatch_q <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= '0;
      wrapc_q    <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      mismatch_q <= mismatch_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      wrapc_q    <= wrapc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    case (state_q)
      HUNT: if (valid && seed_ok) begin
        run_d   = 8'd1;
        state_d = (LOCK_THRESH == 1) ? LOCKED : VERIFY;
      end
      VERIFY: if (valid) begin
        if (hit) begin
          run_d = run_q + 8'd1;
          if ((run_q + 8'd1) >= 8'(LOCK_THRESH)) state_d = LOCKED;
        end else begin
          run_d   = '0;
          state_d = HUNT;
        end
      end
      LOCKED: if (valid && !hit) begin
        run_d   = '0;
        state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    load       = (state_q == HUNT) && valid && seed_ok;
    advance    = (state_q != HUNT) && valid && hit;
    clear      = (state_q != HUNT) && valid && !hit;
    mismatch_d = (state_q == LOCKED) && valid && !hit;
    wrap_d     = (state_q == LOCKED) && valid && hit && (sample == TOP_POW);
    err_d      = (mismatch_d && (err_q != '1)) ? err_q + CNT_W'(1) : err_q;
    wrapc_d    = (wrap_d && (wrapc_q != '1)) ? wrapc_q + CNT_W'(1) : wrapc_q;
  end

  jerky_expect_gen #(.WIDTH(WIDTH)) u_expect (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (load),
    .advance_i  (advance),
    .clear_i    (clear),
    .sample_i   (bus.count_in),
    .expected_o (expected)
  );

`ifdef JERKY_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] first_err_q;
  logic             first_vld_q;
  always_ff @(posedge clock) begin
    if (!reset) begin
      first_err_q <= '0;
      first_vld_q <= 1'b0;
    end else if (mismatch_d && !first_vld_q) begin
      first_err_q <= bus.count_in;
      first_vld_q <= 1'b1;
    end
  end
  assign bus.first_err     = first_err_q;
  assign bus.first_err_vld = first_vld_q;
`endif

  assign bus.locked     = (state_q == LOCKED);
  assign bus.expected   = expected;
  assign bus.mismatch   = mismatch_q;
  assign bus.wrap       = wrap_q;
  assign bus.err_count  = err_q;
  assign bus.wrap_count = wrapc_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_jerky_checker.sv
// Bench for jerky_checker: a default instance and a CNT_W=2 instance share one stimulus stream.
// The reference model walks a table of the pattern period instead of tracking powers of two.
module tb_jerky_checker;
  import jerky_pkg::*;

  localparam int W  = 8;
  localparam int TH = 4;
  localparam int P  = 2 * (W - 1);

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  jerky_checker_if #(.WIDTH(W), .CNT_W(8)) bi ();
  jerky_checker_if #(.WIDTH(W), .CNT_W(2)) bs ();

  jerky_checker #(.WIDTH(W), .LOCK_THRESH(TH), .CNT_W(8)) dut     (.clock(clk), .reset(rst_n), .bus(bi));
  jerky_checker #(.WIDTH(W), .LOCK_THRESH(TH), .CNT_W(2)) dut_sat (.clock(clk), .reset(rst_n), .bus(bs));

  // Reference model: mode 0 hunt, 1 verify, 2 locked; m_pos indexes the expected entry of pat[].
  int pat[P];
  int m_mode, m_pos, m_run, m_err, m_wrap, m_fe;
  bit m_mis, m_wrp, m_fv;

  function automatic int m_exp();
    return (m_mode == 0) ? 0 : pat[m_pos];
  endfunction

  function automatic chk_state_t m_state();
    return (m_mode == 0) ? HUNT : (m_mode == 1) ? VERIFY : LOCKED;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_run = 0; m_err = 0; m_wrap = 0;
    m_mis = 0; m_wrp = 0; m_fv = 0; m_fe = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    bit found;
    m_mis = 0;
    m_wrp = 0;
    if (v === 1'b1) begin
      if (m_mode == 0) begin
        found = 0;
        for (int k = 1; k < W; k++) begin
          if (!found && d === 8'(1 << k)) begin
            found  = 1;
            m_pos  = (2 * k) % P;
            m_run  = 1;
            m_mode = (TH == 1) ? 2 : 1;
          end
        end
      end else if (d === 8'(pat[m_pos])) begin
        if (m_mode == 2 && m_pos == P - 1) begin
          m_wrp = 1;
          m_wrap++;
        end
        m_pos = (m_pos + 1) % P;
        if (m_mode == 1) begin
          m_run++;
          if (m_run >= TH) m_mode = 2;
        end
      end else begin
        if (m_mode == 2) begin
          m_mis = 1;
          m_err++;
          if (!m_fv) begin
            m_fv = 1;
            m_fe = int'(d);
          end
        end
        m_mode = 0;
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    bi.count_valid = v; bi.count_in = d;
    bs.count_valid = v; bs.count_in = d;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(v, d);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 8'h02);
    n_checks++;
    if ({bi.locked, bi.expected, bi.mismatch, bi.wrap, bi.err_count, bi.wrap_count} !== 26'd0
        || bi.dbg_state !== HUNT) begin
      n_fail++;
      $display("FAIL reset_outputs: got locked=%b exp=%0d mis=%b wrap=%b err=%0d wrc=%0d st=%0d, want all 0",
               bi.locked, bi.expected, bi.mismatch, bi.wrap, bi.err_count, bi.wrap_count, bi.dbg_state);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_seed_lock();
    logic [7:0] seq[6] = '{8'd1, 8'd2, 8'd1, 8'd4, 8'd1, 8'd8};
    logic [7:0] want_exp[6] = '{8'd0, 8'd1, 8'd4, 8'd1, 8'd8, 8'd1};
    bit want_lock[6] = '{0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, seq[i]);
      n_checks++;
      if (bi.locked !== want_lock[i] || bi.expected !== want_exp[i] || bi.err_count !== 8'd0) begin
        n_fail++;
        $display("FAIL seed_lock[%0d]: got locked=%b exp=%0d err=%0d, want locked=%b exp=%0d err=0",
                 i, bi.locked, bi.expected, bi.err_count, want_lock[i], want_exp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seq[10] = '{8'd1, 8'd16, 8'd1, 8'd32, 8'd1, 8'd64, 8'd1, 8'd128, 8'd1, 8'd2};
    for (int i = 0; i < 10; i++) begin
      step(1'b1, seq[i]);
      n_checks++;
      if (bi.wrap !== (i == 7) || bi.mismatch !== 1'b0 || bi.locked !== 1'b1
          || bi.wrap_count !== ((i >= 7) ? 8'd1 : 8'd0)) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got wrap=%b mis=%b locked=%b wrc=%0d, want wrap=%b mis=0 locked=1 wrc=%0d",
                 i, bi.wrap, bi.mismatch, bi.locked, bi.wrap_count, (i == 7), (i >= 7) ? 1 : 0);
      end
    end
    n_checks++;
    if (bi.expected !== 8'd1) begin
      n_fail++;
      $display("FAIL wrap_expected: got %0d want 1", bi.expected);
    end
  endtask

  task automatic test_valid_gap();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'hA5);
      n_checks++;
      if (bi.mismatch !== 1'b0 || bi.locked !== 1'b1 || bi.expected !== 8'd1) begin
        n_fail++;
        $display("FAIL valid_gap[%0d]: got mis=%b locked=%b exp=%0d, want mis=0 locked=1 exp=1",
                 i, bi.mismatch, bi.locked, bi.expected);
      end
    end
    step(1'b1, 8'd1);
    step(1'b1, 8'd4);
    n_checks++;
    if (bi.mismatch !== 1'b0 || bi.locked !== 1'b1 || bi.expected !== 8'd1) begin
      n_fail++;
      $display("FAIL gap_resume: got mis=%b locked=%b exp=%0d, want mis=0 locked=1 exp=1",
               bi.mismatch, bi.locked, bi.expected);
    end
  endtask

  task automatic test_fault();
    step(1'b1, 8'd8);
    n_checks++;
    if (bi.mismatch !== 1'b1 || bi.err_count !== 8'd1 || bi.locked !== 1'b0 || bi.expected !== 8'd0) begin
      n_fail++;
      $display("FAIL fault: got mis=%b err=%0d locked=%b exp=%0d, want mis=1 err=1 locked=0 exp=0",
               bi.mismatch, bi.err_count, bi.locked, bi.expected);
    end
`ifdef JERKY_CHECKER_CAPTURE_EN
    n_checks++;
    if (bi.first_err !== 8'd8 || bi.first_err_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL first_err: got %0d vld=%b, want 8 vld=1", bi.first_err, bi.first_err_vld);
    end
`endif
    step(1'b0, 8'hxx);
    n_checks++;
    if (bi.mismatch !== 1'b0 || bi.err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL fault_pulse_width: got mis=%b err=%0d, want mis=0 err=1", bi.mismatch, bi.err_count);
    end
  endtask

  task automatic test_reset_mid_lock();
    step(1'b1, 8'd2); step(1'b1, 8'd1); step(1'b1, 8'd4); step(1'b1, 8'd1);
    n_checks++;
    if (bi.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL relock: got locked=%b want 1", bi.locked);
    end
    rst_n = 1'b0;
    step(1'b1, 8'd8);
    rst_n = 1'b1;
    n_checks++;
    if (bi.locked !== 1'b0 || bi.expected !== 8'd0 || bi.err_count !== 8'd0
        || bi.wrap_count !== 8'd0 || bi.dbg_state !== HUNT) begin
      n_fail++;
      $display("FAIL reset_mid_lock: got locked=%b exp=%0d err=%0d wrc=%0d st=%0d, want all 0 / HUNT",
               bi.locked, bi.expected, bi.err_count, bi.wrap_count, bi.dbg_state);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] want_sat[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst_n = 1'b0;
    step(1'b0, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'd2); step(1'b1, 8'd1); step(1'b1, 8'd4); step(1'b1, 8'd1);
      step(1'b1, 8'd2);
      n_checks++;
      if (bs.err_count !== want_sat[i] || bi.err_count !== 8'(i + 1) || bs.mismatch !== 1'b1) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got sat_err=%0d err=%0d mis=%b, want sat_err=%0d err=%0d mis=1",
                 i, bs.err_count, bi.err_count, bs.mismatch, want_sat[i], i + 1);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] d;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        step(1'b0, 8'hxx);
      end else begin
        if (r < 14) d = 8'($urandom_range(0, 255));
        else if (m_mode == 0) d = 8'(pat[$urandom_range(0, P - 1)]);
        else d = 8'(m_exp());
        step(1'b1, d);
      end
      n_checks++;
      if (bi.locked !== (m_mode == 2) || bi.expected !== 8'(m_exp()) || bi.mismatch !== m_mis
          || bi.wrap !== m_wrp || bi.err_count !== 8'((m_err > 255) ? 255 : m_err)
          || bi.wrap_count !== 8'((m_wrap > 255) ? 255 : m_wrap)
          || bs.err_count !== 2'((m_err > 3) ? 3 : m_err) || bi.dbg_state !== m_state()) begin
        n_fail++;
        $display("FAIL random[%0d]: got L=%b E=%0d M=%b W=%b EC=%0d WC=%0d SE=%0d ST=%0d want L=%b E=%0d M=%b W=%b EC=%0d WC=%0d ST=%0d",
                 i, bi.locked, bi.expected, bi.mismatch, bi.wrap, bi.err_count, bi.wrap_count,
                 bs.err_count, bi.dbg_state, (m_mode == 2), m_exp(), m_mis, m_wrp, m_err, m_wrap, m_state());
      end
`ifdef JERKY_CHECKER_CAPTURE_EN
      n_checks++;
      if (bi.first_err_vld !== m_fv || (m_fv && bi.first_err !== 8'(m_fe))) begin
        n_fail++;
        $display("FAIL random_first_err[%0d]: got %0d vld=%b want %0d vld=%b",
                 i, bi.first_err, bi.first_err_vld, m_fe, m_fv);
      end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < P; i++) pat[i] = (i % 2 == 0) ? 1 : (1 << ((i + 1) / 2));
    model_reset();
    rst_n = 1'b0;
    bi.count_valid = 1'b0; bi.count_in = '0;
    bs.count_valid = 1'b0; bs.count_in = '0;
    test_reset();
    test_seed_lock();
    test_wrap();
    test_valid_gap();
    test_fault();
    test_reset_mid_lock();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
